// File: rtl/argmax_loader.sv
// Serial-to-parallel loader: packs N M-bit scores into one M*N-bit frame for argmax.
// Optional ARGMAX_LOADER_PINGPONG_EN: two banks, so filling continues while a frame is presented.
//
// state | meaning (single-bank build)
// FILL  | accepting words into the bank, out_valid low
// FULL  | frame complete and presented, input stalled until out handshake
module argmax_loader #(
    parameter int N  = 10,
    parameter int M  = 32,
    parameter int CW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [M-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [M*N-1:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    fill_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic          accept;
    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    logic [IW-1:0] wr_idx;

    assign accept   = in_valid && in_ready;
    assign wr_idx   = fill_cnt_q[IW-1:0];
    assign fill_cnt = fill_cnt_q;

    always_comb begin
        fill_cnt_d = fill_cnt_q;
        if (flush) begin
            fill_cnt_d = '0;
        end else if (accept) begin
            fill_cnt_d = (fill_cnt_q == LAST) ? '0 : fill_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q <= '0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
        end
    end

`ifdef ARGMAX_LOADER_PINGPONG_EN
    logic [1:0][N-1:0][M-1:0] bank_q;
    logic [1:0]               full_q;
    logic                     wr_ptr_q;
    logic                     rd_ptr_q;

    assign in_ready  = !full_q[wr_ptr_q] && !flush;
    assign out_valid = full_q[rd_ptr_q];
    // With nothing presented rd_ptr == wr_ptr, so this shows the bank being filled.
    assign out_data  = bank_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q   <= '0;
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (accept) begin
                bank_q[wr_ptr_q][wr_idx] <= in_data;
                if (fill_cnt_q == LAST) begin
                    full_q[wr_ptr_q] <= 1'b1;
                    wr_ptr_q         <= !wr_ptr_q;
                end
            end
            // Accept needs the write bank empty, handshake needs the read bank full,
            // so the two never touch the same full flag in one cycle.
            if (out_valid && out_ready) begin
                full_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= !rd_ptr_q;
            end
        end
    end
`else
    typedef enum logic {FILL, FULL} state_e;

    state_e               state_q, state_d;
    logic [N-1:0][M-1:0]  bank_q;

    assign out_data = bank_q;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = !flush;
                if (in_valid && !flush && (fill_cnt_q == LAST)) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                bank_q[wr_idx] <= in_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_argmax_loader.sv
// Self-checking bench for argmax_loader (N=4, M=8): directed cases plus a random scoreboard run.
module tb_argmax_loader;

    localparam int N  = 4;
    localparam int M  = 8;
    localparam int CW = 3;
`ifdef ARGMAX_LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [M-1:0]      in_data;
    logic              in_valid;
    logic              in_ready;
    logic [M*N-1:0]    out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     fill_cnt;

    argmax_loader #(.N(N), .M(M), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill_cnt  (fill_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int gap_cnt = 0;
    int frames_seen = 0;

    logic [M*N-1:0] sb[$];
    logic [M*N-1:0] cur = '0;
    int             k = 0;
    logic           prev_v = 1'b0;
    logic [M*N-1:0] prev_d = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: model accepts words on the observed handshake and compares frames on out handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            k      = 0;
            cur    = '0;
            prev_v = 1'b0;
            sb.delete();
        end else begin
            check("fill_cnt_model", 64'(fill_cnt), 64'(k));
            if (prev_v) begin
                check("out_hold_valid", 64'(out_valid), 64'd1);
                check("out_stable", 64'(out_data), 64'(prev_d));
            end
            if (out_valid && out_ready) begin
                check("frame_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    check("frame_data", 64'(out_data), 64'(sb.pop_front()));
                end
                frames_seen++;
            end
            if (flush) begin
                k = 0;
            end else if (in_valid && in_ready) begin
                cur[k*M +: M] = in_data;
                k++;
                if (k == N) begin
                    sb.push_back(cur);
                    k = 0;
                end
            end
            prev_v = out_valid && !out_ready;
            prev_d = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call aligned to posedge+1; returns aligned to posedge+1 after the accepting edge.
    task automatic send(input logic [M-1:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        gap_cnt += t;
        if (t >= 50) check("send_ready_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (out_valid && t < 20) begin
            tick();
            t++;
        end
        out_ready = 1'b0;
        check("drain_done", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        logic acc;
        rst_n = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fill_cnt", 64'(fill_cnt), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Frame held with out_ready low
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_out_data", 64'(out_data), 64'h44332211);
        check("t1_in_ready", 64'(in_ready), 64'(PP));
        check("t1_fill_cnt", 64'(fill_cnt), 64'd0);
        repeat (5) tick();
        check("t1_hold_data", 64'(out_data), 64'h44332211);
        check("t1_hold_valid", 64'(out_valid), 64'd1);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_out_valid", 64'(out_valid), 64'd0);
        check("t2_in_ready", 64'(in_ready), 64'd1);
        check("t2_fill_cnt", 64'(fill_cnt), 64'd0);

        // Flush discards the partial frame
        send(8'hAA); send(8'hBB);
        check("t3_fill_pre", 64'(fill_cnt), 64'd2);
        flush = 1'b1;
        #1;
        check("t3_flush_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        check("t3_flush_fill", 64'(fill_cnt), 64'd0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("t3_out_data", 64'(out_data), 64'h04030201);
        check("t3_out_valid", 64'(out_valid), 64'd1);
        check("t3_fill_cnt", 64'(fill_cnt), 64'd0);
        drain();

        // Asynchronous reset mid-frame
        send(8'h05); send(8'h06); send(8'h07);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", 64'(out_valid), 64'd0);
        check("t4_rst_fill", 64'(fill_cnt), 64'd0);
        check("t4_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
        check("t4_out_data", 64'(out_data), 64'h0D0C0B0A);
        drain();

        // Streaming with out_ready held high
        tick();
        out_ready = 1'b1;
        gap_cnt = 0;
        f0 = frames_seen;
        for (int i = 1; i <= 12; i++) send(8'(i));
        check("t5_gaps", 64'(gap_cnt), PP ? 64'd0 : 64'd2);
        repeat (3) tick();
        out_ready = 1'b0;
        check("t5_frames", 64'(frames_seen - f0), 64'd3);
        check("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Random traffic
        f0 = frames_seen;
        for (int i = 0; i < 2000; i++) begin
            if (!in_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("rand_sb_empty", 64'(sb.size()), 64'd0);
        check("rand_frames_seen", 64'(frames_seen - f0 > 50), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
